// File: rtl/rv32i_exec_mem_ctrl.sv
// rv32i_exec_mem_ctrl
//   Execute/memory slice of the rv32i single-cycle core. It contains the main
//   control decoder, the ALU with its operand-B mux, and the word-addressed
//   data BRAM. The BRAM also has an initialisation write path that is used
//   while init_done is low.
//
// Ports
//   clk, rst                   clock and synchronous active-high reset
//   instruction                opcode [6:0], func3 [14:12], func7 [31:25]
//   rs1, rs2, immediate        operands; rs2 is also the store data
//   init_done                  0: init_w_* port writes the BRAM
//                              1: the core store path writes the BRAM
//   init_w_addr/dat/enb        initialisation write port (byte address)
//   debug_addr, debug_data     debug read port (byte address)
//   branch, imm_src, alu_src, reg_write, mem_read, mem_write, mem_2_reg,
//   wrt_back_src, second_u_type_add_src
//                              control decoder outputs
//   alu_results, alu_zero      ALU result (also the data address) and zero flag
//   mem_rdata                  BRAM load data; 0 when not loading
//
// Optional feature macro: DMEM_DEBUG_PORT_EN
//   Defined   : debug_data = mem[debug_addr[9:2]], combinational, ignores rst.
//   Undefined : debug_data is tied to 0 and debug_addr is unused.
module rv32i_exec_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int DMEM_WORDS     = 256,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instruction,
  input  logic [DATA_WIDTH-1:0]     rs1,
  input  logic [DATA_WIDTH-1:0]     rs2,
  input  logic [DATA_WIDTH-1:0]     immediate,
  input  logic                      init_done,
  input  logic [MEM_ADDR_WIDTH-1:0] init_w_addr,
  input  logic [DATA_WIDTH-1:0]     init_w_dat,
  input  logic                      init_w_enb,
  input  logic [MEM_ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0]     debug_data,
  output logic                      branch,
  output logic [2:0]                imm_src,
  output logic                      alu_src,
  output logic                      reg_write,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      mem_2_reg,
  output logic [1:0]                wrt_back_src,
  output logic                      second_u_type_add_src,
  output logic [DATA_WIDTH-1:0]     alu_results,
  output logic                      alu_zero,
  output logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int IDX_W = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] WB_MEMORY_READ    = 2'd0;
  localparam logic [1:0] WB_ALU_RESULTS    = 2'd1;
  localparam logic [1:0] WB_PC_PLUS_4      = 2'd2;
  localparam logic [1:0] WB_U_TYPE_SEC_SRC = 2'd3;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_5;
  alu_op_t    alu_op;

  assign opcode  = instruction[6:0];
  assign func3   = instruction[14:12];
  assign func7_5 = instruction[30];

  // Everything except branch; branch needs alu_zero and is kept in its own
  // block so there is no combinational path back into this one.
  always_comb begin
    imm_src               = IMM_I;
    alu_src               = 1'b0;
    reg_write             = 1'b0;
    mem_read              = 1'b0;
    mem_write             = 1'b0;
    mem_2_reg             = 1'b0;
    wrt_back_src          = WB_MEMORY_READ;
    second_u_type_add_src = 1'b0;
    if (!rst) begin
      case (opcode)
        OP_R: begin
          reg_write    = 1'b1;
          wrt_back_src = WB_ALU_RESULTS;
        end
        OP_I: begin
          alu_src      = 1'b1;
          reg_write    = 1'b1;
          wrt_back_src = WB_ALU_RESULTS;
        end
        OP_LOAD: begin
          mem_read  = 1'b1;
          mem_2_reg = 1'b1;
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_STORE: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          imm_src   = IMM_S;
        end
        OP_BRANCH: imm_src = IMM_B;
        OP_JAL: begin
          reg_write    = 1'b1;
          wrt_back_src = WB_PC_PLUS_4;
          imm_src      = IMM_J;
        end
        OP_JALR: begin
          reg_write    = 1'b1;
          wrt_back_src = WB_PC_PLUS_4;
        end
        OP_LUI, OP_AUIPC: begin
          reg_write             = 1'b1;
          wrt_back_src          = WB_U_TYPE_SEC_SRC;
          imm_src               = IMM_U;
          second_u_type_add_src = (opcode == OP_LUI);
        end
        default: ;
      endcase
    end
  end

  // ALU operation: loads/stores always add, branches compare, everything else
  // follows func3 (SUB only exists for R-type; SRA is selected by func7[5]).
  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OP_BRANCH) begin
      case (func3)
        3'b000, 3'b001: alu_op = ALU_SUB;
        3'b100, 3'b101: alu_op = ALU_SLT;
        3'b110, 3'b111: alu_op = ALU_SLTU;
        default:        alu_op = ALU_ADD;
      endcase
    end else if (opcode != OP_LOAD && opcode != OP_STORE) begin
      case (func3)
        3'b000:  alu_op = (opcode == OP_R && func7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = func7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] operand_b;
  logic [4:0]            shamt;

  assign operand_b = alu_src ? immediate : rs2;
  assign shamt     = operand_b[4:0];

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_results = rs1 + operand_b;
      ALU_SUB:  alu_results = rs1 - operand_b;
      ALU_SLL:  alu_results = rs1 << shamt;
      ALU_SLT:  alu_results = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1) < $signed(operand_b)};
      ALU_SLTU: alu_results = {{(DATA_WIDTH-1){1'b0}}, rs1 < operand_b};
      ALU_XOR:  alu_results = rs1 ^ operand_b;
      ALU_SRL:  alu_results = rs1 >> shamt;
      ALU_SRA:  alu_results = $unsigned($signed(rs1) >>> shamt);
      ALU_OR:   alu_results = rs1 | operand_b;
      default:  alu_results = rs1 & operand_b;
    endcase
  end

  assign alu_zero = (alu_results == '0);

  // beq/bge/bgeu take on a zero compare result, bne/blt/bltu on non-zero.
  always_comb begin
    branch = 1'b0;
    if (!rst) begin
      case (opcode)
        OP_JAL, OP_JALR: branch = 1'b1;
        OP_BRANCH: begin
          case (func3)
            3'b000, 3'b101, 3'b111: branch = alu_zero;
            3'b001, 3'b100, 3'b110: branch = !alu_zero;
            default:                branch = 1'b0;
          endcase
        end
        default: branch = 1'b0;
      endcase
    end
  end

  // Data BRAM. No reset on the array; power-up contents come from the device
  // configuration (all zero).
  logic [DATA_WIDTH-1:0] mem_reg [DMEM_WORDS];
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [IDX_W-1:0]      rd_idx;

  assign wr_en   = init_done ? mem_write : init_w_enb;
  assign wr_idx  = init_done ? alu_results[IDX_W+1:2] : init_w_addr[IDX_W+1:2];
  assign wr_data = init_done ? rs2 : init_w_dat;
  assign rd_idx  = alu_results[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
  end

  // Asynchronous read: a same-cycle write shows up only after the edge.
  assign mem_rdata = (!rst && mem_read) ? mem_reg[rd_idx] : '0;

`ifdef DMEM_DEBUG_PORT_EN
  assign debug_data = mem_reg[debug_addr[IDX_W+1:2]];
`else
  assign debug_data = '0;
`endif

  // Instruction fields the slice does not decode and address bits outside
  // the word index are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{instruction, alu_results, init_w_addr, debug_addr};

endmodule

// File: tb/tb_rv32i_exec_mem_ctrl.sv
// Self-checking bench for rv32i_exec_mem_ctrl: directed steps from the test
// plan followed by randomized instructions checked against a behavioural
// model (instruction semantics plus a word array for the data memory).
module tb_rv32i_exec_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, rs1, rs2, immediate;
  logic        init_done;
  logic [9:0]  init_w_addr;
  logic [31:0] init_w_dat;
  logic        init_w_enb;
  logic [9:0]  debug_addr;
  logic [31:0] debug_data;
  logic        branch;
  logic [2:0]  imm_src;
  logic        alu_src, reg_write, mem_read, mem_write, mem_2_reg;
  logic [1:0]  wrt_back_src;
  logic        second_u_type_add_src;
  logic [31:0] alu_results;
  logic        alu_zero;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  rv32i_exec_mem_ctrl dut (
    .clk(clk), .rst(rst), .instruction(instruction), .rs1(rs1), .rs2(rs2),
    .immediate(immediate), .init_done(init_done), .init_w_addr(init_w_addr),
    .init_w_dat(init_w_dat), .init_w_enb(init_w_enb), .debug_addr(debug_addr),
    .debug_data(debug_data), .branch(branch), .imm_src(imm_src),
    .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_2_reg(mem_2_reg), .wrt_back_src(wrt_back_src),
    .second_u_type_add_src(second_u_type_add_src), .alu_results(alu_results),
    .alu_zero(alu_zero), .mem_rdata(mem_rdata)
  );

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                 K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_BAD = 9;

  int tests = 0;
  int failed = 0;
  logic [31:0] model_mem [256];
  logic [31:0] last_res, last_rdata;
  logic [11:0] last_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] obs_ctrl();
    return {branch, imm_src, alu_src, reg_write, mem_read, mem_write,
            mem_2_reg, wrt_back_src, second_u_type_add_src};
  endfunction

  // Expected control word, field order as obs_ctrl().
  function automatic logic [11:0] exp_ctrl(input int kind, input logic taken);
    case (kind)
      K_R:     return {1'b0,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
      K_I:     return {1'b0,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
      K_LD:    return {1'b0,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
      K_ST:    return {1'b0,  3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
      K_BR:    return {taken, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      K_JAL:   return {1'b1,  3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
      K_JALR:  return {1'b1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
      K_LUI:   return {1'b0,  3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
      K_AUIPC: return {1'b0,  3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};
      default: return 12'd0;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Random filler in rd/rs1/rs2 fields; decoded fields forced.
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] r;
    r = $urandom();
    r[6:0]   = op;
    r[14:12] = f3;
    r[31:25] = f7;
    return r;
  endfunction

  // Integer semantics of the RV32I arithmetic instructions.
  function automatic logic [31:0] ref_arith(input logic [2:0] f3, input logic sub, input logic sra,
                                            input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return sub ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return sra ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Apply one instruction for one cycle, check everything observable, then
  // advance one clock edge (updating the memory model for stores).
  task automatic run_op(input string tag, input int kind, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] bsel, exp_res, exp_rd;
    logic        taken;
    logic [7:0]  idx;
    instruction = mk(op_of(kind), f3, f7);
    rs1 = a; rs2 = b; immediate = imm;
    #2;
    bsel  = (kind == K_I || kind == K_LD || kind == K_ST) ? imm : b;
    taken = 1'b0;
    case (kind)
      K_R, K_I: exp_res = ref_arith(f3, kind == K_R && f3 == 3'd0 && f7[5], f3 == 3'd5 && f7[5], a, bsel);
      K_BR: begin
        case (f3)
          3'd0: begin exp_res = a - b; taken = (a == b); end
          3'd1: begin exp_res = a - b; taken = (a != b); end
          3'd4: begin exp_res = ref_arith(3'd2, 1'b0, 1'b0, a, b); taken = $signed(a) <  $signed(b); end
          3'd5: begin exp_res = ref_arith(3'd2, 1'b0, 1'b0, a, b); taken = $signed(a) >= $signed(b); end
          3'd6: begin exp_res = ref_arith(3'd3, 1'b0, 1'b0, a, b); taken = a <  b; end
          default: begin exp_res = ref_arith(3'd3, 1'b0, 1'b0, a, b); taken = a >= b; end
        endcase
      end
      default: exp_res = a + bsel;
    endcase
    idx    = 8'(exp_res >> 2);
    exp_rd = (kind == K_LD) ? model_mem[idx] : 32'd0;
    last_res   = alu_results;
    last_rdata = mem_rdata;
    last_ctrl  = obs_ctrl();
    chk({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(kind, taken)));
    if (kind <= K_BR) begin
      chk({tag, ".alu"}, alu_results, exp_res);
      chk({tag, ".zero"}, 32'(alu_zero), 32'(exp_res == 32'd0));
    end
    chk({tag, ".rdata"}, mem_rdata, exp_rd);
    $display("[TB] %s kind=%0d f3=%0d a=%08h b=%08h imm=%08h alu=%08h ctrl=%03h rdata=%08h",
             tag, kind, f3, a, b, imm, alu_results, obs_ctrl(), mem_rdata);
    step();
    if (kind == K_ST) model_mem[idx] = b;
  endtask

  initial begin
    logic [31:0] d, a, b, imm, oldv;
    logic [7:0]  w;
    logic [2:0]  f3;
    int          kind;

    rst = 1'b1; init_done = 1'b1; init_w_addr = '0; init_w_dat = '0; init_w_enb = 1'b0;
    debug_addr = '0; rs1 = 32'd0; rs2 = 32'h1234_5678; immediate = 32'h10;
    instruction = mk(op_of(K_ST), 3'd2, 7'd0);
    #2;
    chk("reset.ctrl", 32'(obs_ctrl()), 32'd0);
    chk("reset.rdata", mem_rdata, 32'd0);
    step(); step();
    rst = 1'b0;

    // Fill every word through the init port while the core presents a store
    // that must be ignored because init_done is low.
    init_done = 1'b0;
    init_w_enb = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = 8'(i);
      d = $urandom();
      init_w_addr = {w, 2'($urandom_range(0, 3))};
      init_w_dat  = d;
      rs1 = $urandom(); immediate = 32'd0; rs2 = $urandom();
      instruction = mk(op_of(K_ST), 3'd2, 7'd0);
      step();
      model_mem[w] = d;
    end
    for (int i = 0; i < 5; i++) begin
      init_w_addr = 10'(i * 4);
      init_w_dat  = 32'd5;
      step();
      model_mem[i] = 32'd5;
    end
    init_w_enb = 1'b0;
    init_done = 1'b1;

    run_op("lw_0xC", K_LD, 3'd2, 7'd0, 32'hC, 32'd0, 32'd0);
    chk("init.word3", last_rdata, 32'd5);
    run_op("lw_0xA", K_LD, 3'd2, 7'd0, 32'hA, 32'd0, 32'd0);
    chk("init.alias_word2", last_rdata, 32'd5);
    debug_addr = 10'hC;
    #1;
`ifdef DMEM_DEBUG_PORT_EN
    chk("debug.0xC", debug_data, 32'd5);
    debug_addr = 10'hA;
    #1;
    chk("debug.0xA", debug_data, 32'd5);
`else
    chk("debug.tied", debug_data, 32'd0);
`endif

    run_op("slti", K_I, 3'd2, 7'($urandom()), 32'd5, 32'd0, 32'd10);
    chk("slti.res", last_res, 32'd1);
    run_op("slti_neg", K_I, 3'd2, 7'd0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    chk("slti_neg.res", last_res, 32'd1);
    run_op("sltiu", K_I, 3'd3, 7'd0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    chk("sltiu.res", last_res, 32'd0);

    run_op("sw_0xC", K_ST, 3'd2, 7'd0, 32'd0, 32'd1, 32'hC);
    chk("sw.mem_write", 32'(last_ctrl[4]), 32'd1);
`ifdef DMEM_DEBUG_PORT_EN
    debug_addr = 10'hC;
    #1;
    chk("sw.debug", debug_data, 32'd1);
`endif
    run_op("lw_after_sw", K_LD, 3'd2, 7'd0, 32'd0, 32'd0, 32'hC);
    chk("lw.rdata", last_rdata, 32'd1);
    chk("lw.wb_src", 32'(last_ctrl[2:1]), 32'd0);

    run_op("beq", K_BR, 3'd0, 7'd0, 32'd7, 32'd7, 32'd0);
    chk("beq.branch", 32'(last_ctrl[11]), 32'd1);
    run_op("bne", K_BR, 3'd1, 7'd0, 32'd7, 32'd7, 32'd0);
    chk("bne.branch", 32'(last_ctrl[11]), 32'd0);
    run_op("blt", K_BR, 3'd4, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("blt.branch", 32'(last_ctrl[11]), 32'd1);
    run_op("bltu", K_BR, 3'd6, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("bltu.branch", 32'(last_ctrl[11]), 32'd0);

    run_op("lui", K_LUI, 3'($urandom()), 7'($urandom()), 32'd3, 32'd4, 32'h1000);
    chk("lui.wb_su", 32'(last_ctrl[2:0]), 32'b111);
    run_op("jal", K_JAL, 3'($urandom()), 7'($urandom()), 32'd3, 32'd4, 32'h8);
    chk("jal.br_wb", 32'({last_ctrl[11], last_ctrl[2:1]}), 32'b110);
    run_op("auipc", K_AUIPC, 3'd0, 7'd0, 32'd3, 32'd4, 32'h1000);
    run_op("jalr", K_JALR, 3'd0, 7'd0, 32'd3, 32'd4, 32'h8);
    run_op("unknown", K_BAD, 3'd2, 7'd0, 32'd3, 32'd4, 32'h8);

    // Init-port write and load of the same word in one cycle.
    oldv = model_mem[3];
    d = $urandom();
    init_done = 1'b0; init_w_enb = 1'b1; init_w_addr = 10'hC; init_w_dat = d;
    instruction = mk(op_of(K_LD), 3'd2, 7'd0); rs1 = 32'hC; immediate = 32'd0;
    #2;
    chk("rdw.old", mem_rdata, oldv);
    step();
    model_mem[3] = d;
    init_w_enb = 1'b0;
    #1;
    chk("rdw.new", mem_rdata, d);
    init_done = 1'b1;

    // Reset during a store: outputs forced to 0 and the word is untouched.
    rst = 1'b1;
    instruction = mk(op_of(K_ST), 3'd2, 7'd0); rs1 = 32'h10; immediate = 32'd0; rs2 = 32'hDEAD_BEEF;
    #2;
    chk("rst_store.ctrl", 32'(obs_ctrl()), 32'd0);
    chk("rst_store.rdata", mem_rdata, 32'd0);
    step();
    rst = 1'b0;
    run_op("lw_after_rst", K_LD, 3'd2, 7'd0, 32'h10, 32'd0, 32'd0);
    chk("rst_store.kept", last_rdata, 32'd5);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom(); b = $urandom(); imm = $urandom();
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) imm = 32'($signed(12'($urandom())));
      f3 = 3'($urandom());
      if (kind == K_BR) begin
        while (f3 == 3'd2 || f3 == 3'd3) f3 = 3'($urandom());
      end
      run_op("rand", kind, f3, {1'b0, 1'($urandom()), 5'($urandom())}, a, b, imm);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
